sram_1r1w_bypass: RTL
=====================

Name: sram_1r1w_bypass

Overview:
- Parametrised single-clock 1-write/1-read SRAM model. It is the successor to the fixed 64x512 dual-port macro models.
- Adds generic width, depth and byte-lane write masks, plus selectable read latency and read-during-write forwarding.
- Adds a registered read-valid output and collision reporting.
- Used as the behavioural and synthesizable stand-in for register-file and cache RAM macros in the core.

Parameters:
- DATA_WIDTH, 64, read/write data width; must equal NUM_WMASKS*LANE_W.
- NUM_WMASKS, 8, number of write-mask lanes; LANE_W = DATA_WIDTH/NUM_WMASKS.
- ADDR_WIDTH, 9, address width.
- RAM_DEPTH, 512, number of words; must be <= 2**ADDR_WIDTH.
- OUT_REG, 0, 0: read latency 1 cycle; 1: extra output register, latency 2.
- BYPASS, 1, 1: same-cycle write data forwarded to read; 0: read returns pre-write data.
- CNT_WIDTH, 16, width of saturating collision counter.

Ports:
- clk  input  1  clock, all logic on posedge
- rst_n  input  1  asynchronous active-low reset
- csb0  input  1  write port select, active low
- wmask0  input  NUM_WMASKS  per-lane write enable, active high
- addr0  input  ADDR_WIDTH  write address
- din0  input  DATA_WIDTH  write data
- csb1  input  1  read port select, active low
- addr1  input  ADDR_WIDTH  read address
- dout1  output  DATA_WIDTH  read data
- dout1_valid  output  1  one-cycle pulse, dout1 carries a new read result
- collision  output  1  qualifies dout1_valid; the read collided with a same-address write
- coll_count  output  CNT_WIDTH  saturating count of collisions since reset

Behaviour:
- Reset (rst_n low, async):
  - dout1=0, dout1_valid=0, collision=0, coll_count=0.
  - All pipeline valid flags are cleared; in-flight reads are discarded.
  - Memory array is not reset. Writes are suppressed while rst_n is low.
- Write, at posedge with !csb0:
  - For each lane i with wmask0[i]=1, mem[addr0][i*LANE_W +: LANE_W] <= din0 lane i.
  - Unmasked lanes keep their contents. wmask0=0 with !csb0 is a no-op.
- Read request, at posedge with !csb1:
  - Read word = mem[addr1] as it was before this edge's write.
- Collision (hit): !csb0 && !csb1 && addr0==addr1 && |wmask0, all at the same edge.
  - BYPASS=1: lanes with wmask0 set take din0; other lanes take old data.
  - BYPASS=0: all lanes take old data.
- Out-of-range address (addr >= RAM_DEPTH):
  - Write is ignored.
  - Read returns all zeros with dout1_valid asserted.
  - Never counts as a collision.
- Latency with OUT_REG=0:
  - Result lands in dout1 at the request edge; dout1_valid=1 for the following cycle.
- Latency with OUT_REG=1:
  - Result passes through a stage-1 register, then into dout1 one edge later; dout1_valid is one cycle later than with OUT_REG=0.
  - Stage 1 carries data, valid and hit.
- Output hold:
  - dout1 holds its last value when no new read completes (no X, no T_HOLD blanking).
  - dout1_valid and collision are single-cycle pulses aligned with each new dout1.
  - Back-to-back reads give a continuous valid, one result per cycle.
- Collision counter:
  - coll_count increments by 1 on each cycle where collision=1.
  - It saturates at 2**CNT_WIDTH-1, and only reset clears it.
- Reset asserted mid-read (OUT_REG=1): the stage-1 result is dropped, and no valid appears after release.
- Write and read at different addresses in the same cycle: fully independent.
- Simulation: the model issues no $display. Parameter checks (divisibility, depth) are elaboration-time errors.

Test Plan:
- Reset/hold:
  - Stimulus: assert rst_n=0 mid-stream, then release.
  - Required: dout1=0, valid=0, coll_count=0 immediately.
  - Required: a read issued before reset produces no valid after release.
- Masked write, no collision (defaults):
  - Stimulus: write addr 5 din=0x1122334455667788 wmask=0xFF, then write addr 5 din=0xAAAAAAAAAAAAAAAA wmask=0x0F, then read 5.
  - Required: dout1=0x11223344AAAAAAAA, valid 1 cycle after the read.
- Forwarding, BYPASS=1:
  - Stimulus: mem[7]=0; same cycle write addr 7 din=0xFFFF_FFFF_FFFF_FFFF wmask=0x81 and read addr 7.
  - Required: dout1=0xFF000000000000FF, collision=1, coll_count=1.
- Old-data mode, BYPASS=0:
  - Stimulus: same as the forwarding scenario.
  - Required: dout1=0, collision=1; a following read of 7 returns 0xFF000000000000FF with collision=0.
- OUT_REG=1 pipelining:
  - Stimulus: reads of 1, 2 and 3 on consecutive cycles with mem[n]=n.
  - Required: dout1=1, 2, 3 on cycles 2, 3 and 4 after the first request, with valid high for 3 cycles.
- Saturation/range:
  - Stimulus: CNT_WIDTH=2, 5 collisions.
  - Required: coll_count=3.
  - Stimulus: RAM_DEPTH=500, read addr 510.
  - Required: dout1=0 with valid=1; a write to 510 leaves mem untouched.

Source files
------------

// File: rtl/sram_1r1w_bypass.sv
// sram_1r1w_bypass: parametrised single-clock 1-write/1-read SRAM model with
// byte-lane write masks, optional output register, read-during-write
// forwarding and a saturating collision counter.
module sram_1r1w_bypass #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_WMASKS = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int RAM_DEPTH  = 512,
  parameter int OUT_REG    = 0,
  parameter int BYPASS     = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  csb0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  collision,
  output logic [CNT_WIDTH-1:0]  coll_count
);

  localparam int LANE_W = DATA_WIDTH / NUM_WMASKS;

  // Configuration errors are caught at elaboration rather than in simulation.
  if (DATA_WIDTH != NUM_WMASKS * LANE_W) begin : g_bad_width
    $error("sram_1r1w_bypass: DATA_WIDTH must be a multiple of NUM_WMASKS");
  end
  if (RAM_DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_depth
    $error("sram_1r1w_bypass: RAM_DEPTH exceeds the address space");
  end

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  rd_req;
  logic                  hit;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] rd_word;

  // Addresses past the populated depth neither write nor collide, and read as zero.
  assign wr_in_range = (32'(addr0) < RAM_DEPTH);
  assign rd_in_range = (32'(addr1) < RAM_DEPTH);
  assign rd_req      = !csb1;
  assign hit         = !csb0 && !csb1 && (addr0 == addr1) && (|wmask0) && rd_in_range;

  // Fetch the pre-write contents of the read address.
  always_comb begin
    old_word = '0;
    if (rd_in_range) begin
      old_word = mem[addr1];
    end
  end

  // Overlay the written lanes onto the read word when forwarding is enabled.
  always_comb begin
    rd_word = old_word;
    if ((BYPASS != 0) && hit) begin
      for (int i = 0; i < NUM_WMASKS; i++) begin
        if (wmask0[i]) begin
          rd_word[i*LANE_W +: LANE_W] = din0[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // Lane-masked array write; the array itself is never reset and is frozen during reset.
  always_ff @(posedge clk) begin
    if (rst_n && !csb0 && wr_in_range) begin
      for (int i = 0; i < NUM_WMASKS; i++) begin
        if (wmask0[i]) begin
          mem[addr0][i*LANE_W +: LANE_W] <= din0[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_valid;
    logic                  s1_hit;

    // Stage 1 captures the read result; reset drops any read in flight.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_data  <= '0;
        s1_valid <= 1'b0;
        s1_hit   <= 1'b0;
      end else begin
        s1_valid <= rd_req;
        s1_hit   <= hit;
        if (rd_req) begin
          s1_data <= rd_word;
        end
      end
    end

    // Output stage moves stage 1 into dout1 and holds it between results.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout1       <= '0;
        dout1_valid <= 1'b0;
        collision   <= 1'b0;
      end else begin
        dout1_valid <= s1_valid;
        collision   <= s1_valid && s1_hit;
        if (s1_valid) begin
          dout1 <= s1_data;
        end
      end
    end
  end else begin : g_no_out_reg
    // Single-cycle read: result lands at the request edge and holds afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout1       <= '0;
        dout1_valid <= 1'b0;
        collision   <= 1'b0;
      end else begin
        dout1_valid <= rd_req;
        collision   <= hit;
        if (rd_req) begin
          dout1 <= rd_word;
        end
      end
    end
  end

  // Count every cycle that reports a collision, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_count <= '0;
    end else if (collision && (coll_count != {CNT_WIDTH{1'b1}})) begin
      coll_count <= coll_count + 1'b1;
    end
  end

endmodule
